// File: rtl/intr_priority_ctrl.sv
// -----------------------------------------------------------------------------
// intr_priority_ctrl
//   Interrupt controller between sticky error-cause sources and a CPU irq line.
//   Captures per-source pending bits, gates them with per-source enables,
//   picks one eligible source (fixed priority or round-robin) and presents it
//   on a registered irq/irq_id pair, then runs a claim/complete handshake.
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   rst         in   1      asynchronous, active-high reset
//   src_i       in   N_SRC  error causes (level or 1-cycle pulse)
//   en_i        in   N_SRC  per-source enable (gates arbitration only)
//   claim_i     in   1      CPU accepts the presented interrupt
//   complete_i  in   1      CPU finished servicing the claimed interrupt
//   irq_o       out  1      interrupt request (flop)
//   irq_id_o    out  ID_W   presented / claimed source id (flop)
//   pending_o   out  N_SRC  sticky pending register (flop)
//   busy_o      out  1      claimed and not yet completed (flop)
//   state_o     out  2      FSM state for observation: 0=IDLE 1=ASSERT 2=SERVICE
//
// Handshake: while irq_o=1 (ASSERT) the id on irq_id_o is frozen; a 1-cycle
// claim_i pulse accepts it (busy_o rises next cycle). complete_i is a 1-cycle
// pulse accepted only while busy_o=1. claim_i outside ASSERT and complete_i
// outside SERVICE have no effect; both in ASSERT counts as a claim only.
// -----------------------------------------------------------------------------
module intr_priority_ctrl #(
   parameter int N_SRC       = 8,
   parameter int ID_W        = 3,
   parameter int ROUND_ROBIN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_i,
   input  logic [N_SRC-1:0] en_i,
   input  logic             claim_i,
   input  logic             complete_i,
   output logic             irq_o,
   output logic [ID_W-1:0]  irq_id_o,
   output logic [N_SRC-1:0] pending_o,
   output logic             busy_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [N_SRC-1:0]  elig;
   logic [N_SRC-1:0]  clr_mask;
   logic [ID_W-1:0]   start;
   logic [ID_W:0]     idx;
   logic [ID_W-1:0]   arb_id;
   logic              any_elig;

   assign state_o  = state;
   assign elig     = pending_o & en_i;
   assign any_elig = |elig;

   // Search origin: 0 for fixed priority, one past the last claimed id for
   // round-robin (wrapping at N_SRC, which need not be a power of two).
   always_comb begin
      start = '0;
      if (ROUND_ROBIN != 0) begin
         if (rr_ptr == ID_W'(N_SRC - 1)) start = '0;
         else                            start = rr_ptr + 1'b1;
      end
   end

   // Walk offsets from the far end toward the origin so the candidate closest
   // to the origin is the last one written and therefore wins.
   always_comb begin
      arb_id = '0;
      idx    = '0;
      for (int off = N_SRC - 1; off >= 0; off--) begin
         idx = {1'b0, start} + (ID_W + 1)'(off);
         if (idx >= (ID_W + 1)'(N_SRC)) idx = idx - (ID_W + 1)'(N_SRC);
         if (elig[idx[ID_W-1:0]]) arb_id = idx[ID_W-1:0];
      end
   end

   // Only an accepted claim clears a pending bit; src_i is OR-ed in after the
   // clear so a new event in the claim cycle is not lost.
   always_comb begin
      clr_mask = '0;
      if (state == ASSERT && claim_i) clr_mask[irq_id_o] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         irq_o     <= 1'b0;
         irq_id_o  <= '0;
         busy_o    <= 1'b0;
         pending_o <= '0;
         rr_ptr    <= ID_W'(N_SRC - 1);
      end else begin
         pending_o <= (pending_o & ~clr_mask) | src_i;
         case (state)
            IDLE: begin
               if (any_elig) begin
                  irq_id_o <= arb_id;
                  irq_o    <= 1'b1;
                  state    <= ASSERT;
               end
            end
            ASSERT: begin
               if (claim_i) begin
                  irq_o  <= 1'b0;
                  busy_o <= 1'b1;
                  rr_ptr <= irq_id_o;
                  state  <= SERVICE;
               end else if (!en_i[irq_id_o]) begin
                  // Source masked while presented: withdraw, keep it pending.
                  irq_o <= 1'b0;
                  state <= IDLE;
               end
            end
            SERVICE: begin
               if (complete_i) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               irq_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
